polyvec_decompress_ctrl: RTL and testbench
==========================================

POLYVEC_DECOMPRESS_CTRL -- requirements
Module: polyvec_decompress_ctrl

Interface
REQ-001 SHALL have parameter K, default 2: polynomials per vector, legal 2..4.
REQ-002 SHALL have parameter AW, default 8: read/write address width; K*64 SHALL be at most 2^AW.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 start  in  1  one-cycle request to decompress one packed polyvec.
REQ-006 abort  in  1  synchronous cancel of a running job.
REQ-007 busy  out  1  high from the cycle after start is accepted until done or abort.
REQ-008 done  out  1  one-cycle completion pulse.
REQ-009 rd_en  out  1  packed-ciphertext RAM read strobe; RAM read latency is 1 cycle.
REQ-010 rd_addr  out  AW  40-bit (5-byte) word index.
REQ-011 rd_data  in  40  RAM read data; byte 0 in bits [39:32].
REQ-012 dp_a  out  40  operand to the 10-bit unpack datapath; datapath is registered, latency 1.
REQ-013 dp_t  in  64  unpack result: four 16-bit lanes, first coefficient in [63:48].
REQ-014 wr_en  out  1  coefficient RAM write strobe.
REQ-015 wr_addr  out  AW  coefficient-group index; group g holds coefficients 4g..4g+3.
REQ-016 wr_data  out  64  four 16-bit coefficients, same lane order as dp_t.

Function
REQ-017 SHALL implement states IDLE, RUN, DRAIN, DONE.
REQ-018 IDLE: start=1 -> RUN, read counter cleared to 0; start in any other state SHALL be ignored.
REQ-019 RUN: rd_en=1 every cycle, rd_addr = counter, counter +1; after issuing address K*64-1 -> DRAIN; the counter SHALL NOT wrap.
REQ-020 dp_a SHALL be rd_data passed combinationally.
REQ-021 Valid/address shift pipeline SHALL track each read; wr_en SHALL assert 3 cycles after the matching rd_en, with wr_addr equal to that rd_addr.
REQ-022 wr_data SHALL be registered; each lane = dp_t lane bits [9:0] zero-extended to 16 bits (bits [15:10] forced to 0).
REQ-023 DRAIN: remain until the pipeline holds no valid entry -> DONE; DONE SHALL last one cycle with done=1, then -> IDLE.
REQ-024 Exactly K*64 writes per job, at strictly increasing wr_addr 0..K*64-1, with no gaps.
REQ-025 abort in RUN or DRAIN: next cycle state=IDLE, all pipeline valids cleared, rd_en=0, wr_en=0, no done pulse; abort in IDLE or DONE ignored; abort and start together in IDLE -> start wins.
REQ-026 busy SHALL be high in RUN and DRAIN, and low in IDLE and DONE.

Reset
REQ-027 rst_n=0 SHALL immediately force IDLE and drive busy, done, rd_en, wr_en to 0, rd_addr, wr_addr, and wr_data to 0, and clear all valids and counters, including mid-job.
REQ-028 After rst_n deasserts, the first start SHALL be accepted normally.

Configuration
REQ-029 Macro POLYVEC_DECOMPRESS_SCALE_EN: when defined, each lane x = dp_t lane [9:0] SHALL be replaced by ((x*3329)+512)>>10, zero-extended to 16 bits, in one extra registered stage; write latency becomes 4 cycles after rd_en and DRAIN lengthens accordingly.
REQ-030 Without the macro, no multiplier SHALL be present and the latency of REQ-021 holds.

Verification
REQ-031 Reset, K=2, start at cycle 0 -> rd_en cycles 1..128, wr_en cycles 4..131, done at cycle 132, busy cycles 1..131.
REQ-032 rd_data word 0 = 40'h01_00_00_00_00 -> first write: wr_addr 0, wr_data 64'h0001_0000_0000_0000; with SCALE_EN, 64'h0003_0000_0000_0000.
REQ-033 rd_data = 40'hFF_FF_FF_FF_FF at all addresses -> every wr_data = 64'h03FF_03FF_03FF_03FF; with SCALE_EN, 64'h0CFE_0CFE_0CFE_0CFE.
REQ-034 abort at cycle 50 -> wr_en low from cycle 51, busy low at cycle 51, no done; a new start then produces 128 writes from address 0.
REQ-035 start pulsed while busy at cycle 20 -> ignored; exactly 128 writes and one done.
REQ-036 rst_n low at cycle 60 mid-job -> all outputs 0 asynchronously; after release, start -> full nominal job.

Source files
------------

// File: rtl/polyvec_decompress_ctrl.sv
// rtl/polyvec_decompress_ctrl.sv - packed polyvec read / 10-bit unpack / coefficient write sequencer
// Optional POLYVEC_DECOMPRESS_SCALE_EN adds a registered ((x*3329)+512)>>10 lane stage.
module polyvec_decompress_ctrl #(
    parameter int K  = 2,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [39:0]   rd_data,
    output logic [39:0]   dp_a,
    input  logic [63:0]   dp_t,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [63:0]   wr_data
);

    localparam int NW = K * 64;
    localparam logic [AW-1:0] LAST_ADDR = AW'(NW - 1);

`ifdef POLYVEC_DECOMPRESS_SCALE_EN
    localparam int NSTG = 4;
`else
    localparam int NSTG = 3;
`endif

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]      state;
    logic [AW-1:0]   cnt;
    logic [NSTG-1:0] vld;
    logic [AW-1:0]   pa [NSTG];
    logic            unused_dp;

    assign busy    = (state == S_RUN) || (state == S_DRAIN);
    assign done    = (state == S_DONE);
    assign rd_en   = (state == S_RUN);
    assign rd_addr = cnt;
    assign dp_a    = rd_data;
    assign wr_en   = vld[NSTG-1];
    assign wr_addr = pa[NSTG-1];

    assign unused_dp = ^{dp_t[63:58], dp_t[47:42], dp_t[31:26], dp_t[15:10]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_RUN;
                        cnt   <= '0;
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        state <= S_IDLE;
                    end else if (cnt == LAST_ADDR) begin
                        state <= S_DRAIN;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DRAIN: begin
                    // Leave one cycle early: the last stage is writing this cycle.
                    if (abort) begin
                        state <= S_IDLE;
                    end else if (vld[NSTG-2:0] == '0) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
            for (int i = 0; i < NSTG; i++) begin
                pa[i] <= '0;
            end
        end else begin
            if (abort && busy) begin
                vld <= '0;
            end else begin
                vld <= {vld[NSTG-2:0], rd_en};
            end
            pa[0] <= rd_addr;
            for (int i = 1; i < NSTG; i++) begin
                pa[i] <= pa[i-1];
            end
        end
    end

`ifdef POLYVEC_DECOMPRESS_SCALE_EN
    function automatic logic [15:0] scale_lane(input logic [9:0] x);
        return {4'b0, 12'((22'(x) * 22'd3329 + 22'd512) >> 10)};
    endfunction

    logic [63:0] scl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl     <= '0;
            wr_data <= '0;
        end else begin
            if (vld[1]) begin
                for (int i = 0; i < 4; i++) begin
                    scl[63-16*i -: 16] <= scale_lane(dp_t[57-16*i -: 10]);
                end
            end
            if (vld[2]) begin
                wr_data <= scl;
            end
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_data <= '0;
        end else if (vld[1]) begin
            for (int i = 0; i < 4; i++) begin
                wr_data[63-16*i -: 16] <= {6'b0, dp_t[57-16*i -: 10]};
            end
        end
    end
`endif

endmodule

// File: tb/tb_polyvec_decompress_ctrl.sv
// tb/tb_polyvec_decompress_ctrl.sv - scoreboard bench for polyvec_decompress_ctrl
module tb_polyvec_decompress_ctrl;

    localparam int K  = 2;
    localparam int AW = 8;
    localparam int NW = K * 64;
`ifdef POLYVEC_DECOMPRESS_SCALE_EN
    localparam int LAT = 4;
    localparam logic [63:0] FIRST_EXP = 64'h0003_0000_0000_0000;
    localparam logic [63:0] FF_EXP    = 64'h0CFE_0CFE_0CFE_0CFE;
`else
    localparam int LAT = 3;
    localparam logic [63:0] FIRST_EXP = 64'h0001_0000_0000_0000;
    localparam logic [63:0] FF_EXP    = 64'h03FF_03FF_03FF_03FF;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          busy, done, rd_en, wr_en;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [39:0]   rd_data = '0;
    logic [39:0]   dp_a;
    logic [63:0]   dp_t = '0;
    logic [63:0]   wr_data;

    polyvec_decompress_ctrl #(.K(K), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .dp_a(dp_a), .dp_t(dp_t),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [7:0]  addr;
        logic [63:0] data;
    } ent_t;

    logic [39:0] mem [0:255];
    ent_t q[$];
    int cyc = 0;
    int n_checks = 0;
    int n_errors = 0;
    int busy_cnt, done_cnt, done_cyc, rd_cnt, rd_first, wr_cnt;
    bit chk_first, chk_ff;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [9:0] unpack(input logic [39:0] w, input int i);
        logic [7:0] b0, b1, b2, b3, b4;
        b0 = w[39:32]; b1 = w[31:24]; b2 = w[23:16]; b3 = w[15:8]; b4 = w[7:0];
        case (i)
            0: return {b1[1:0], b0};
            1: return {b2[3:0], b1[7:2]};
            2: return {b3[5:0], b2[7:4]};
            default: return {b4, b3[7:6]};
        endcase
    endfunction

    function automatic logic [63:0] exp_word(input logic [39:0] w);
        logic [63:0] r;
        int x;
        for (int i = 0; i < 4; i++) begin
            x = int'(unpack(w, i));
`ifdef POLYVEC_DECOMPRESS_SCALE_EN
            x = ((x * 3329) + 512) >> 10;
`endif
            r[63-16*i -: 16] = 16'(x);
        end
        return r;
    endfunction

    // External RAM (1-cycle read) and unpack datapath; lane upper bits carry junk.
    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
        for (int i = 0; i < 4; i++) begin
            dp_t[63-16*i -: 16] <= {6'b101101, unpack(dp_a, i)};
        end
        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        ent_t e;
        if (rst_n) begin
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (rd_en) begin
                if (rd_cnt == 0) rd_first = cyc;
                rd_cnt++;
                e.cyc = cyc;
                e.addr = rd_addr;
                e.data = exp_word(mem[rd_addr]);
                q.push_back(e);
            end
            if (wr_en) begin
                wr_cnt++;
                if (q.size() == 0) begin
                    check("wr_unexpected", 64'(wr_en), 64'(0));
                end else begin
                    e = q.pop_front();
                    check("wr_addr", 64'(wr_addr), 64'(e.addr));
                    check("wr_data", wr_data, e.data);
                    check("wr_lat", 64'(cyc - e.cyc), 64'(LAT));
                    if (chk_first && e.addr == 8'd0) check("first_const", wr_data, FIRST_EXP);
                    if (chk_ff) check("ff_const", wr_data, FF_EXP);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_counts();
        busy_cnt = 0; done_cnt = 0; done_cyc = -1;
        rd_cnt = 0; rd_first = -1; wr_cnt = 0;
        q.delete();
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"}, 64'(busy), 64'(0));
        check({tag, "_done"}, 64'(done), 64'(0));
        check({tag, "_rd_en"}, 64'(rd_en), 64'(0));
        check({tag, "_wr_en"}, 64'(wr_en), 64'(0));
        check({tag, "_rd_addr"}, 64'(rd_addr), 64'(0));
        check({tag, "_wr_addr"}, 64'(wr_addr), 64'(0));
        check({tag, "_wr_data"}, wr_data, 64'(0));
    endtask

    // Full nominal job; ign_at = cycle offset of a stray start while busy (-1 none).
    task automatic do_job(input int ign_at, input bit with_abort);
        int c0;
        clear_counts();
        c0 = cyc;
        start = 1'b1;
        abort = with_abort;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("busy_after_start", 64'(busy), 64'(1));
        for (int i = 1; i < 128 + LAT + 10; i++) begin
            if (i == ign_at) start = 1'b1;
            tick();
            start = 1'b0;
        end
        check("done_cnt", 64'(done_cnt), 64'(1));
        check("done_cyc", 64'(done_cyc - c0), 64'(NW + LAT + 1));
        check("busy_cnt", 64'(busy_cnt), 64'(NW + LAT));
        check("rd_cnt", 64'(rd_cnt), 64'(NW));
        check("rd_first", 64'(rd_first - c0), 64'(1));
        check("wr_cnt", 64'(wr_cnt), 64'(NW));
        check("queue_empty", 64'(q.size()), 64'(0));
        check("idle_busy", 64'(busy), 64'(0));
    endtask

    initial begin
        int c0, wr_snap;
        for (int i = 0; i < 256; i++) mem[i] = {$urandom, 8'($urandom)};
        mem[0] = 40'h01_00_00_00_00;
        clear_counts();
        chk_first = 1'b0;
        chk_ff = 1'b0;

        tick(); tick();
        check_outputs_zero("reset");
        rst_n = 1'b1;
        tick();

        // Abort alone in IDLE is ignored.
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("idle_abort_busy", 64'(busy), 64'(0));

        chk_first = 1'b1;
        do_job(-1, 1'b0);
        chk_first = 1'b0;

        for (int i = 0; i < 256; i++) mem[i] = 40'hFF_FF_FF_FF_FF;
        chk_ff = 1'b1;
        do_job(20, 1'b0);
        chk_ff = 1'b0;

        for (int i = 0; i < 256; i++) mem[i] = {$urandom, 8'($urandom)};
        do_job(-1, 1'b1);

        // Abort at cycle 50.
        clear_counts();
        c0 = cyc;
        start = 1'b1;
        tick();
        start = 1'b0;
        while (cyc < c0 + 50) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        q.delete();
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_wr_en", 64'(wr_en), 64'(0));
        check("abort_rd_en", 64'(rd_en), 64'(0));
        wr_snap = wr_cnt;
        for (int i = 0; i < 10; i++) tick();
        check("abort_no_wr", 64'(wr_cnt), 64'(wr_snap));
        check("abort_no_done", 64'(done_cnt), 64'(0));
        do_job(-1, 1'b0);

        // Asynchronous reset mid-job at cycle 60.
        clear_counts();
        c0 = cyc;
        start = 1'b1;
        tick();
        start = 1'b0;
        while (cyc < c0 + 60) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midreset");
        tick(); tick();
        rst_n = 1'b1;
        tick();
        check("post_reset_busy", 64'(busy), 64'(0));
        do_job(-1, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
